// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM states, key map and scan classification.
package keypad_defs;

  localparam int COL_CYCLES_DEF     = 100000;
  localparam int DEBOUNCE_SCANS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  typedef struct packed {
    scan_kind_e kind;
    logic [3:0] code;
  } scan_result_t;

  // Indexed by col*4 + row, which is the snapshot bit layout.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic scan_result_t classify(input logic [15:0] snap);
    scan_result_t res;
    logic [4:0]   n;
    res.kind = SCAN_NONE;
    res.code = 4'h0;
    n        = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        n        = n + 5'd1;
        res.code = KEY_MAP[i];
      end
    end
    if (n == 5'd1) begin
      res.kind = SCAN_SINGLE;
    end else if (n > 5'd1) begin
      res.kind = SCAN_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_column_driver.sv
// Walks one active-low column across the keypad, synchronises the rows and
// assembles a 16-bit pressed-key snapshot, pulsing scan_done after column 3.
module keypad_column_driver import keypad_defs::*; #(
  parameter int COL_CYCLES = COL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] snapshot,
  output logic        scan_done
);

  localparam int            CW   = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(COL_CYCLES - 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          done_q, done_d;
  logic          slot_end;

  assign slot_end = (cnt_q == LAST);

  always_comb begin
    cnt_d  = slot_end ? '0 : cnt_q + CW'(1);
    idx_d  = slot_end ? idx_q + 2'd1 : idx_q;
    snap_d = snap_q;
    // Rows are active-low; store 1 for a closed key.
    if (slot_end) begin
      snap_d[{idx_q, 2'b00} +: 4] = ~sync2_q;
    end
    done_d = slot_end && (idx_q == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
    end
  end

  assign col       = ~(4'b0001 << idx_q);
  assign snapshot  = snap_q;
  assign scan_done = done_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: debounces full scans and emits one key_valid pulse per press.
// Handshake: key_valid is a one-cycle strobe with no ready; key_code is stable from that cycle until the next accept.
module keypad_scanner import keypad_defs::*; #(
  parameter int COL_CYCLES     = COL_CYCLES_DEF,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output kp_state_e  dbg_state
);

  localparam int              CNTW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEBOUNCE_SCANS);

  logic [15:0]     snapshot;
  logic            scan_done;
  scan_result_t    scan;
  kp_state_e       state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic            is_single, is_cand, accept;

  keypad_column_driver #(.COL_CYCLES(COL_CYCLES)) u_cols (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .snapshot  (snapshot),
    .scan_done (scan_done)
  );

  assign scan      = classify(snapshot);
  assign is_single = (scan.kind == SCAN_SINGLE);
  assign is_cand   = is_single && (scan.code == cand_q);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    accept  = 1'b0;
    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = scan.code;
            cnt_d  = CNTW'(1);
            if (DEBOUNCE_SCANS == 1) accept = 1'b1;
            else                     state_d = PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (is_cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) accept = 1'b1;
          end else if (is_single) begin
            cand_d = scan.code;
            cnt_d  = CNTW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (!is_cand) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = IDLE;
              held_d  = 1'b0;
            end else begin
              state_d = RELEASE_CHK;
              cnt_d   = CNTW'(1);
            end
          end
        end
        RELEASE_CHK: begin
          if (is_cand) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = IDLE;
              held_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept) begin
      code_d  = cand_d;
      valid_d = 1'b1;
      held_d  = 1'b1;
      state_d = HELD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cand_q  <= 4'h0;
      cnt_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign dbg_state = state_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad on a Pmod port by driving one column low at a time and reading the row lines.
- Debounces the result and emits one key-code event per physical press.
- It is the input-side counterpart of the meter's 7-segment display driver, which writes to its port. This block reads the keypad used for payment and rate entry.
- It sits beside the sensor and debouncer blocks in parking_meter, clocked by the raw board clk.

Parameters:
- COL_CYCLES, 100000, clk cycles each column is driven before its rows are sampled (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- row  input  4  keypad row lines, asynchronous, active-low (pulled up, 0 = key closed to the driven column).
- col  output  4  keypad column drives, active-low, exactly one bit 0 at any time.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  single-cycle pulse when a new press is accepted.
- key_held  output  1  high while an accepted key is still considered pressed.

Behaviour:
- Reset (rst==0 at a clk edge):
  - col=4'b1110, key_code=0, key_valid=0, key_held=0.
  - Slot counter=0, scan snapshot cleared, FSM=IDLE, debounce count=0.
  - A reset mid-scan or mid-debounce abandons all progress; no key_valid is emitted for the abandoned scan.
- Synchroniser: row passes through a 2-flop synchroniser before any use.
- Column slot:
  - A counter runs 0..COL_CYCLES-1 per column.
  - On count COL_CYCLES-1, the inverted synchronised row is stored into snapshot[col_idx*4 +: 4].
  - col_idx then advances 0->1->2->3->0, and col becomes ~(1<<col_idx).
  - Full scan = 4*COL_CYCLES cycles.
  - The sample point lies at least 3 cycles after the column change, which covers synchroniser latency.
- Scan evaluation, in the cycle after the column-3 sample:
  - Exactly one snapshot bit set -> "single(k)".
  - Zero bits set -> "none".
  - Two or more bits set -> "multi", treated as none (ghost rejection).
- Key map (row r, column c), key_code values:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- FSM, one transition per evaluation:
  - IDLE:
    - single(k) -> cand=k, cnt=1.
    - If DEBOUNCE_SCANS==1, accept immediately; otherwise go to PRESS_CHK.
  - PRESS_CHK:
    - single(cand) -> cnt++.
    - When cnt reaches DEBOUNCE_SCANS -> accept.
    - single(other) -> cand=other, cnt=1, stay in PRESS_CHK.
    - none/multi -> IDLE.
  - Accept action:
    - key_code<=cand and key_valid=1 for exactly one cycle (the evaluation cycle +1 register stage, fixed).
    - key_held<=1, FSM -> HELD.
  - HELD:
    - single(cand) -> stay.
    - Anything else -> RELEASE_CHK with cnt=1; with DEBOUNCE_SCANS==1, go straight to IDLE.
  - RELEASE_CHK:
    - single(cand) -> HELD.
    - Anything else -> cnt++.
    - When cnt reaches DEBOUNCE_SCANS -> IDLE, key_held<=0.
- key_code holds its value until the next accept and is never cleared except by reset.
- Holding a key never repeats key_valid.
- A direct roll from key A to key B yields B's key_valid only after A's release has been accepted and B has then passed its own press debounce.
- Counters are sized with $clog2 of their parameter; no wrap occurs beyond terminal values.

Decomposition:
- Shared package/header (keypad_defs):
  - State encodings IDLE/PRESS_CHK/HELD/RELEASE_CHK.
  - The 16-entry key map constant.
  - Default values for COL_CYCLES and DEBOUNCE_SCANS.
- One natural sub-module: keypad_column_driver.
  - Contains the slot counter, col rotation, synchroniser and snapshot register.
  - Outputs a 16-bit snapshot plus a scan_done pulse.
- The debounce FSM and key decoding stay in keypad_scanner.

Test Plan:
All scenarios use COL_CYCLES=8 and DEBOUNCE_SCANS=3 (scan = 32 cycles).
1. Reset, no keys -> col steps 1110,1101,1011,0111 every 8 cycles. key_valid never pulses; key_code=0, key_held=0.
2. Model '5' pressed (row1 low while col1 low) for 10 scans:
   - Exactly one key_valid pulse, one cycle after the 3rd scan evaluation.
   - key_code=4'h5; key_held=1 until 3 scans after release.
3. Bounce on '9': pressed, released, pressed, released on alternating scans -> no key_valid, key_held stays 0.
4. '1' and 'A' pressed together for 6 scans -> no key_valid (multi rejected). Then release 'A' -> key_valid with key_code=4'h1 after 3 single scans.
5. Press 'D' (row3, col3) and accept it. Roll directly to '0' with no idle gap -> key_held drops after 3 scans, then a second key_valid with key_code=4'h0 after 3 more scans.
6. Press '7', assert rst=0 after 2 good scans, release rst -> outputs return to reset values and no pulse occurs. If '7' is still held, key_valid fires after 3 fresh scans.
